mmio_port_unit: RTL

MMIO_PORT_UNIT -- requirements
Module: mmio_port_unit

---
 rtl/mmio_port_unit.sv | 126 ++++++++++++
 1 files changed

// File: rtl/mmio_port_unit.sv
// MEM-stage memory-mapped I/O block: a 256-byte window holding an output port,
// a synchronized input port with change flags, and a free-running cycle counter.
module mmio_port_unit #(
    parameter logic [31:0] IO_BASE   = 32'h1001_0100,
    parameter int          CNT_WIDTH = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] MemAddress,
    input  logic [31:0] MemWriteData,
    input  logic        MemWrite,
    input  logic        MemRead,
    input  logic [7:0]  PortIn,
    output logic        IOHit,
    output logic [31:0] IOReadData,
    output logic        RAMWrite,
    output logic        RAMRead,
    output logic [31:0] PortOut,
    output logic        EdgePending
);

    // Word indices within the window (MemAddress[7:2]).
    localparam logic [5:0] IDX_PORT_OUT = 6'd0;
    localparam logic [5:0] IDX_PORT_IN  = 6'd1;
    localparam logic [5:0] IDX_EDGE     = 6'd2;
    localparam logic [5:0] IDX_CYCLE    = 6'd3;

    logic [31:0]          r_port_out;
    logic [7:0]           r_sync1;
    logic [7:0]           r_sync2;
    logic [7:0]           r_prev;
    logic [7:0]           r_edge;
    logic [CNT_WIDTH-1:0] r_cycle;

    logic                 w_hit;
    logic [5:0]           w_idx;
    logic                 w_io_wr;
    logic                 w_wr_port_out;
    logic                 w_wr_edge;
    logic                 w_wr_cycle;
    logic [7:0]           w_edge_set;
    logic [7:0]           w_edge_clr;
    logic [7:0]           w_edge_next;
    logic [CNT_WIDTH-1:0] w_cycle_next;
    logic [31:0]          w_cycle_ext;
    logic [31:0]          w_rdata;

    // Address decode and RAM strobe gating.
    assign w_hit    = (MemAddress[31:8] == IO_BASE[31:8]);
    assign w_idx    = MemAddress[7:2];
    assign IOHit    = w_hit;
    assign RAMWrite = MemWrite & ~w_hit;
    assign RAMRead  = MemRead & ~w_hit;

    assign w_io_wr       = MemWrite & w_hit;
    assign w_wr_port_out = w_io_wr & (w_idx == IDX_PORT_OUT);
    assign w_wr_edge     = w_io_wr & (w_idx == IDX_EDGE);
    assign w_wr_cycle    = w_io_wr & (w_idx == IDX_CYCLE);

    // A fresh change on the synchronized input overrides a same-cycle clear.
    assign w_edge_set  = r_sync2 ^ r_prev;
    assign w_edge_clr  = w_wr_edge ? MemWriteData[7:0] : 8'h00;
    assign w_edge_next = (r_edge & ~w_edge_clr) | w_edge_set;

    assign w_cycle_next = w_wr_cycle ? MemWriteData[CNT_WIDTH-1:0]
                                     : r_cycle + {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    always_comb begin
        w_cycle_ext                = '0;
        w_cycle_ext[CNT_WIDTH-1:0] = r_cycle;
    end

    always_comb begin
        w_rdata = 32'h0000_0000;
        case (w_idx)
            IDX_PORT_OUT: w_rdata = r_port_out;
            IDX_PORT_IN:  w_rdata = {24'h00_0000, r_sync2};
            IDX_EDGE:     w_rdata = {24'h00_0000, r_edge};
            IDX_CYCLE:    w_rdata = w_cycle_ext;
            default:      w_rdata = 32'h0000_0000;
        endcase
    end

    assign IOReadData = w_rdata;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_port_out <= 32'h0000_0000;
        end else if (w_wr_port_out) begin
            r_port_out <= MemWriteData;
        end
    end

    // Two-flop synchronizer plus history flop for change detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1 <= 8'h00;
            r_sync2 <= 8'h00;
            r_prev  <= 8'h00;
        end else begin
            r_sync1 <= PortIn;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_edge <= 8'h00;
        end else begin
            r_edge <= w_edge_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cycle <= '0;
        end else begin
            r_cycle <= w_cycle_next;
        end
    end

    assign PortOut     = r_port_out;
    assign EdgePending = |r_edge;

endmodule
